updown_counter_param: RTL and testbench
=======================================

# updown_counter_param

Parametrised up/down counter with programmable modulus, count enable, synchronous parallel load, terminal-count flags and a registered wrap/limit event pulse. It is the generalised successor to the fixed 3-bit up/down counter and serves as the counting primitive for timers, address generators and training-data circuits. Width, modulus top and reset value are set per instance. Saturating behaviour is a compile-time option.

## Interface
- WIDTH, 8, counter width in bits (1..32)
- MAX_VAL, 2**WIDTH-1, top of count range; range is 0..MAX_VAL; must satisfy 1 <= MAX_VAL <= 2**WIDTH-1
- RESET_VAL, 0, value loaded on reset; must be <= MAX_VAL
- clk  input  1  rising-edge clock
- rst  input  1  reset; one clock; reset is asynchronous and active-high
- en  input  1  count enable; no step when low
- up_down  input  1  direction: 1 = up, 0 = down
- load  input  1  synchronous parallel load strobe
- load_val  input  WIDTH  value to load
- sat  input  1  saturate mode select (effective only with COUNTER_SATURATE_EN)
- count  output  WIDTH  current count, registered
- at_max  output  1  count == MAX_VAL, combinational from count
- at_min  output  1  count == 0, combinational from count
- event_pulse  output  1  registered one-cycle pulse: wrap occurred or limit hit in previous cycle
- event_dir  output  1  registered direction of last event: 1 = at top, 0 = at bottom

## Operation
- Priority per edge: rst > load > en > hold.
- rst asserted (any time, asynchronous): count = RESET_VAL, event_pulse = 0, event_dir = 0; held while rst high. at_max/at_min follow RESET_VAL.
- load=1: count <= min(load_val, MAX_VAL); load_val > MAX_VAL clamps to MAX_VAL; event_pulse <= 0; en and up_down ignored.
- en=1, load=0, up_down=1: count < MAX_VAL -> count+1; count == MAX_VAL -> wrap to 0, event_pulse <= 1, event_dir <= 1.
- en=1, load=0, up_down=0: count > 0 -> count-1; count == 0 -> wrap to MAX_VAL, event_pulse <= 1, event_dir <= 0.
- Saturate mode (macro present, sat=1): at limit, count holds instead of wrapping; event_pulse <= 1 every enabled cycle spent pushing against the limit, event_dir as above.
- en=0, load=0: count holds, event_pulse <= 0, event_dir holds.
- Arithmetic is modulo MAX_VAL+1, never modulo 2**WIDTH unless MAX_VAL = 2**WIDTH-1; no intermediate value above MAX_VAL ever appears on count.
- Direction change mid-sequence takes effect on the next enabled edge; no dead cycle.
- MAX_VAL = 1: counter toggles 0/1, every enabled step from a limit is a wrap event.

## Timing
- count, event_pulse, event_dir update on rising clk; 1-cycle latency from en/load/up_down to count.
- event_pulse high for exactly the cycle following the wrapping/limit edge; back-to-back events (MAX_VAL=1, or saturate held) give continuous high.
- at_max/at_min valid same cycle as count, no added latency.
- rst release: first count change on the first rising edge with rst low and en or load high.
- All inputs sampled only at rising clk; no combinational input-to-output path.

## Configuration
- COUNTER_SATURATE_EN defined: sat input selects saturate (1) or wrap (0) per cycle; sat may change any cycle.
- COUNTER_SATURATE_EN undefined: sat ignored, counter always wraps; saturation logic not synthesised; port retained for pin compatibility.

## Test plan
- WIDTH=3, MAX_VAL=5, RESET_VAL=0: rst 10 ns then en=1, up_down=1 for 7 edges -> count 1,2,3,4,5,0,1; event_pulse high one cycle after 5->0, event_dir=1; at_max high only at 5.
- Same config, count=0, up_down=0, en=1 -> count 5,4,3; event_pulse with event_dir=0 after 0->5.
- load=1, load_val=7 with MAX_VAL=5 -> count=5 next edge; load and en both high with load_val=2 -> count=2, no step.
- en toggled low for 3 cycles at count=3 -> count holds 3, event_pulse 0; up_down flipped while en=0 -> no change until en returns.
- rst asserted mid-clock-period at count=4 -> count=RESET_VAL immediately (before next edge), event_pulse=0; counting resumes from RESET_VAL after release.
- With COUNTER_SATURATE_EN, sat=1, count=5, up 3 edges -> count stays 5, event_pulse high 3 cycles; sat=0 next edge -> wraps to 0. Without macro, same stimulus wraps to 0 on first edge.

Source files
------------

// File: rtl/updown_counter_param.sv
// updown_counter_param: parametrised up/down counter.
// Features: modulus MAX_VAL+1, count enable, synchronous clamped load, terminal-count
// flags, and a registered wrap/limit event pulse with direction.
// Optional build macro COUNTER_SATURATE_EN enables the per-cycle `sat` input, which
// makes the counter hold at its limits instead of wrapping. With the macro undefined,
// `sat` is ignored and the counter always wraps.
module updown_counter_param #(
  parameter int unsigned        WIDTH     = 8,
  parameter logic [WIDTH-1:0]   MAX_VAL   = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             sat,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             event_pulse,
  output logic             event_dir
);

  logic [WIDTH-1:0] r_count;
  logic             r_event_pulse;
  logic             r_event_dir;

  logic [WIDTH-1:0] w_count_nxt;
  logic             w_event_pulse_nxt;
  logic             w_event_dir_nxt;
  logic [WIDTH-1:0] w_load_clamped;
  logic             w_sat_mode;
  logic             w_at_max;
  logic             w_at_min;

`ifdef COUNTER_SATURATE_EN
  assign w_sat_mode = sat;
`else
  // Saturation hardware is not built; the pin stays for pin compatibility.
  logic w_sat_unused;
  assign w_sat_unused = sat;
  assign w_sat_mode   = 1'b0;
`endif

  assign w_at_max       = (r_count == MAX_VAL);
  assign w_at_min       = (r_count == '0);
  assign w_load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

  // Next-state: load beats enable; a step from a limit either wraps or holds (saturate)
  // and always raises the event pulse, tagged with the direction of travel.
  always_comb begin
    w_count_nxt       = r_count;
    w_event_pulse_nxt = 1'b0;
    w_event_dir_nxt   = r_event_dir;
    if (load) begin
      w_count_nxt = w_load_clamped;
    end else if (en) begin
      if (up_down) begin
        if (w_at_max) begin
          w_event_pulse_nxt = 1'b1;
          w_event_dir_nxt   = 1'b1;
          if (!w_sat_mode) begin
            w_count_nxt = '0;
          end
        end else begin
          w_count_nxt = r_count + WIDTH'(1);
        end
      end else begin
        if (w_at_min) begin
          w_event_pulse_nxt = 1'b1;
          w_event_dir_nxt   = 1'b0;
          if (!w_sat_mode) begin
            w_count_nxt = MAX_VAL;
          end
        end else begin
          w_count_nxt = r_count - WIDTH'(1);
        end
      end
    end
  end

  // State registers; reset forces count to RESET_VAL and clears the event outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count       <= RESET_VAL;
      r_event_pulse <= 1'b0;
      r_event_dir   <= 1'b0;
    end else begin
      r_count       <= w_count_nxt;
      r_event_pulse <= w_event_pulse_nxt;
      r_event_dir   <= w_event_dir_nxt;
    end
  end

  assign count       = r_count;
  assign at_max      = w_at_max;
  assign at_min      = w_at_min;
  assign event_pulse = r_event_pulse;
  assign event_dir   = r_event_dir;

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param (WIDTH=3, MAX_VAL=5, RESET_VAL=0): directed scenarios
// followed by random stimulus, compared against an arithmetic reference model.
module tb_updown_counter_param;

  localparam int W    = 3;
  localparam int MAXV = 5;
  localparam int RSTV = 0;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         up_down;
  logic         load;
  logic [W-1:0] load_val;
  logic         sat;
  logic [W-1:0] count;
  logic         at_max;
  logic         at_min;
  logic         event_pulse;
  logic         event_dir;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_cnt;
  int m_pulse;
  int m_dir;

  updown_counter_param #(
    .WIDTH    (W),
    .MAX_VAL  (3'(MAXV)),
    .RESET_VAL(3'(RSTV))
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .up_down    (up_down),
    .load       (load),
    .load_val   (load_val),
    .sat        (sat),
    .count      (count),
    .at_max     (at_max),
    .at_min     (at_min),
    .event_pulse(event_pulse),
    .event_dir  (event_dir)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check_eq($sformatf("%s.count", tag), int'(count), m_cnt);
    check_eq($sformatf("%s.at_max", tag), int'(at_max), (m_cnt == MAXV) ? 1 : 0);
    check_eq($sformatf("%s.at_min", tag), int'(at_min), (m_cnt == 0) ? 1 : 0);
    check_eq($sformatf("%s.pulse", tag), int'(event_pulse), m_pulse);
    check_eq($sformatf("%s.dir", tag), int'(event_dir), m_dir);
  endtask

  // One clock edge of the reference behaviour: modulo (MAXV+1) arithmetic,
  // with any step that leaves 0..MAXV counted as a limit event.
  task automatic model_edge(input bit e, input bit ud, input bit ld, input int lv, input bit s);
    int  nxt;
    bit  sat_eff;
`ifdef COUNTER_SATURATE_EN
    sat_eff = s;
`else
    sat_eff = 1'b0;
`endif
    if (ld) begin
      m_cnt   = (lv > MAXV) ? MAXV : lv;
      m_pulse = 0;
    end else if (e) begin
      nxt = m_cnt + (ud ? 1 : -1);
      if (nxt > MAXV || nxt < 0) begin
        m_pulse = 1;
        m_dir   = ud ? 1 : 0;
        if (!sat_eff) m_cnt = (nxt + MAXV + 1) % (MAXV + 1);
      end else begin
        m_cnt   = nxt;
        m_pulse = 0;
      end
    end else begin
      m_pulse = 0;
    end
  endtask

  task automatic step(input bit e, input bit ud, input bit ld, input int lv, input bit s,
                      input string tag);
    @(negedge clk);
    en       = e;
    up_down  = ud;
    load     = ld;
    load_val = W'(lv);
    sat      = s;
    @(posedge clk);
    model_edge(e, ud, ld, lv, s);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst      = 1'b1;
    en       = 1'b0;
    up_down  = 1'b1;
    load     = 1'b0;
    load_val = '0;
    sat      = 1'b0;
    m_cnt    = RSTV;
    m_pulse  = 0;
    m_dir    = 0;

    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Count up through the wrap: 1,2,3,4,5,0,1
    for (int i = 0; i < 7; i++) step(1, 1, 0, 0, 0, $sformatf("up%0d", i));

    // Down from 0: 5,4,3
    step(0, 0, 1, 0, 0, "load0");
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, $sformatf("down%0d", i));

    // Load clamping, and load beating enable
    step(0, 1, 1, 7, 0, "load7clamp");
    step(1, 1, 1, 2, 0, "load_en");

    // Hold with en low while direction flips, then resume
    step(1, 1, 0, 0, 0, "to3");
    step(0, 0, 0, 0, 0, "hold0");
    step(0, 1, 0, 0, 0, "hold1");
    step(0, 0, 0, 0, 0, "hold2");
    step(1, 0, 0, 0, 0, "resume_down");
    step(1, 1, 0, 0, 0, "resume_up");
    step(1, 1, 0, 0, 0, "to4");

    // Asynchronous reset in the middle of a clock period
    @(negedge clk);
    en = 1'b0;
    load = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    m_cnt = RSTV; m_pulse = 0; m_dir = 0;
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_held");
    @(negedge clk);
    rst = 1'b0;
    step(1, 1, 0, 0, 0, "after_rst");

    // Pushing against the top limit with sat=1, then releasing sat
    step(0, 1, 1, 5, 1, "load5");
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 1, $sformatf("sat_up%0d", i));
    step(1, 1, 0, 0, 0, "sat_off");
    // Bottom limit with sat=1
    step(1, 0, 0, 0, 1, "sat_down0");
    step(1, 0, 0, 0, 1, "sat_down1");

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0), int'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
